// File: rtl/mips_mem_responder_if.sv
// CPU-side memory bus between the 8-bit multicycle MIPS core and its memory responder.
// The core drives address, data and strobes; the responder returns registered read data.
interface mips_mem_responder_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] writedata;
   logic              memread;
   logic              memwrite;
   logic [DATA_W-1:0] memdata;
   logic              rd_valid;

   modport master (
      output adr,
      output writedata,
      output memread,
      output memwrite,
      input  memdata,
      input  rd_valid
   );

   modport slave (
      input  adr,
      input  writedata,
      input  memread,
      input  memwrite,
      output memdata,
      output rd_valid
   );
endinterface

// File: rtl/mips_mem_responder.sv
// Byte-wide memory behind the MIPS core with a streaming program loader.
// The core is held in reset until the loader finishes or run_start is given.
module mips_mem_responder #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic                clk,
   input  logic                reset,
   mips_mem_responder_if.slave bus,
   input  logic                load_start,
   input  logic                run_start,
   input  logic                load_valid,
   input  logic [DATA_W-1:0]   load_data,
   input  logic                load_last,
   output logic                load_ready,
   output logic [ADDR_W:0]     load_count,
   output logic                cpu_reset,
   output logic                run
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   localparam logic [ADDR_W:0] LastIdx = (ADDR_W+1)'(DEPTH - 1);

   state_e            r_state;
   state_e            w_state_next;
   logic [ADDR_W:0]   r_load_count;
   logic [ADDR_W:0]   w_load_count_next;
   logic [DATA_W-1:0] r_memdata;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic w_xfer;
   logic w_cpu_rd;
   logic w_cpu_wr;

   // load_start pre-empts any transfer offered in the same cycle
   assign load_ready = (r_state == StLoad) && !r_load_count[ADDR_W];
   assign w_xfer     = load_ready && load_valid && !load_start;
   assign w_cpu_rd   = (r_state == StRun) && bus.memread;
   assign w_cpu_wr   = (r_state == StRun) && bus.memwrite;

   assign cpu_reset   = (r_state != StRun);
   assign run         = (r_state == StRun);
   assign load_count  = r_load_count;
   assign bus.memdata  = r_memdata;
   assign bus.rd_valid = r_rd_valid;

   always_comb begin
      w_state_next      = r_state;
      w_load_count_next = r_load_count;
      if (load_start) begin
         w_state_next      = StLoad;
         w_load_count_next = '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (run_start) w_state_next = StRun;
            end
            StLoad: begin
               if (w_xfer) begin
                  w_load_count_next = r_load_count + 1'b1;
                  if (load_last || (r_load_count == LastIdx)) w_state_next = StRun;
               end
            end
            StRun:   w_state_next = StRun;
            default: w_state_next = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= StIdle;
         r_load_count <= '0;
         r_memdata    <= '0;
         r_rd_valid   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_load_count <= w_load_count_next;
         r_rd_valid   <= w_cpu_rd;
         if (w_cpu_rd) r_memdata <= r_mem[bus.adr];
      end
   end

   // Storage has no reset so a loaded program survives a core restart.
   // CPU and loader writes are mutually exclusive by state.
   always_ff @(posedge clk) begin
      if (w_cpu_wr) begin
         r_mem[bus.adr] <= bus.writedata;
      end else if (w_xfer) begin
         r_mem[r_load_count[ADDR_W-1:0]] <= load_data;
      end
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: loader, CPU reads/writes, gating, reload and reset.
module tb_mips_mem_responder;

   logic       clk;
   logic       reset;
   logic       load_start;
   logic       run_start;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic [8:0] load_count;
   logic       cpu_reset;
   logic       run;

   int n_checks;
   int n_fail;

   mips_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   mips_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .load_start (load_start),
      .run_start  (run_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .load_count (load_count),
      .cpu_reset  (cpu_reset),
      .run        (run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if (bus.memdata !== 8'h00) begin
         $display("FAIL reset_memdata got %h want 00", bus.memdata); n_fail++;
      end
      n_checks++;
      if (bus.rd_valid !== 1'b0) begin
         $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); n_fail++;
      end
      n_checks++;
      if (cpu_reset !== 1'b1) begin
         $display("FAIL reset_cpu_reset got %b want 1", cpu_reset); n_fail++;
      end
      n_checks++;
      if (run !== 1'b0) begin
         $display("FAIL reset_run got %b want 0", run); n_fail++;
      end
      n_checks++;
      if (load_ready !== 1'b0) begin
         $display("FAIL reset_load_ready got %b want 0", load_ready); n_fail++;
      end
      n_checks++;
      if (load_count !== 9'd0) begin
         $display("FAIL reset_load_count got %0d want 0", load_count); n_fail++;
      end
   endtask

   task automatic test_load_fetch();
      logic [7:0] prog [4];
      prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h43; prog[3] = 8'h00;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      n_checks++;
      if (load_ready !== 1'b1) begin
         $display("FAIL load_ready_in_load got %b want 1", load_ready); n_fail++;
      end
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 3);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      n_checks++;
      if (load_count !== 9'd4) begin
         $display("FAIL load_count_after_4 got %0d want 4", load_count); n_fail++;
      end
      n_checks++;
      if (run !== 1'b1 || cpu_reset !== 1'b0) begin
         $display("FAIL run_after_last got run=%b cpu_reset=%b want 1/0", run, cpu_reset);
         n_fail++;
      end
      for (int i = 0; i < 4; i++) begin
         bus.memread = 1'b1;
         bus.adr     = 8'(i);
         tick();
         n_checks++;
         if (bus.memdata !== prog[i] || bus.rd_valid !== 1'b1) begin
            $display("FAIL fetch_%0d got data=%h valid=%b want %h/1", i, bus.memdata,
                     bus.rd_valid, prog[i]);
            n_fail++;
         end
      end
      bus.memread = 1'b0;
      tick();
      n_checks++;
      if (bus.rd_valid !== 1'b0 || bus.memdata !== 8'h00) begin
         $display("FAIL fetch_idle_hold got data=%h valid=%b want 00/0", bus.memdata,
                  bus.rd_valid);
         n_fail++;
      end
   endtask

   task automatic test_write_read();
      bus.memwrite  = 1'b1;
      bus.adr       = 8'h80;
      bus.writedata = 8'h5A;
      tick();
      bus.memwrite = 1'b0;
      bus.memread  = 1'b1;
      tick();
      n_checks++;
      if (bus.memdata !== 8'h5A || bus.rd_valid !== 1'b1) begin
         $display("FAIL write_then_read got data=%h valid=%b want 5a/1", bus.memdata,
                  bus.rd_valid);
         n_fail++;
      end
      bus.memwrite  = 1'b1;
      bus.writedata = 8'hA5;
      tick();
      n_checks++;
      if (bus.memdata !== 8'h5A) begin
         $display("FAIL read_before_write got %h want 5a", bus.memdata); n_fail++;
      end
      bus.memwrite = 1'b0;
      tick();
      n_checks++;
      if (bus.memdata !== 8'hA5) begin
         $display("FAIL read_after_rmw got %h want a5", bus.memdata); n_fail++;
      end
      bus.memread = 1'b0;
      tick();
   endtask

   task automatic test_gating();
      bus.memwrite  = 1'b1;
      bus.adr       = 8'h10;
      bus.writedata = 8'h33;
      tick();
      bus.memwrite = 1'b0;
      load_start   = 1'b1;
      tick();
      load_start = 1'b0;
      n_checks++;
      if (cpu_reset !== 1'b1 || load_count !== 9'd0) begin
         $display("FAIL reload_entry got cpu_reset=%b count=%0d want 1/0", cpu_reset,
                  load_count);
         n_fail++;
      end
      bus.memwrite  = 1'b1;
      bus.memread   = 1'b1;
      bus.writedata = 8'hEE;
      tick();
      bus.memwrite = 1'b0;
      bus.memread  = 1'b0;
      n_checks++;
      if (bus.rd_valid !== 1'b0 || bus.memdata !== 8'hA5) begin
         $display("FAIL load_read_gated got data=%h valid=%b want a5/0", bus.memdata,
                  bus.rd_valid);
         n_fail++;
      end
      load_valid = 1'b1;
      load_data  = 8'h20;
      load_last  = 1'b1;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      bus.memread = 1'b1;
      bus.adr     = 8'h10;
      tick();
      bus.memread = 1'b0;
      n_checks++;
      if (bus.memdata !== 8'h33) begin
         $display("FAIL load_write_gated got %h want 33", bus.memdata); n_fail++;
      end
      tick();
   endtask

   task automatic test_full_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) begin
            n_checks++;
            if (load_ready !== 1'b1 || load_count !== 9'd255) begin
               $display("FAIL full_before_last got ready=%b count=%0d want 1/255",
                        load_ready, load_count);
               n_fail++;
            end
         end
         load_valid = 1'b1;
         load_data  = 8'(i);
         tick();
      end
      load_valid = 1'b0;
      n_checks++;
      if (load_ready !== 1'b0 || load_count !== 9'd256 || run !== 1'b1) begin
         $display("FAIL full_load_end got ready=%b count=%0d run=%b want 0/256/1",
                  load_ready, load_count, run);
         n_fail++;
      end
      bus.memread = 1'b1;
      bus.adr     = 8'h00;
      tick();
      n_checks++;
      if (bus.memdata !== 8'h00) begin
         $display("FAIL full_mem0 got %h want 00", bus.memdata); n_fail++;
      end
      bus.adr = 8'hFF;
      tick();
      n_checks++;
      if (bus.memdata !== 8'hFF) begin
         $display("FAIL full_mem255 got %h want ff", bus.memdata); n_fail++;
      end
      bus.adr = 8'h80;
      tick();
      n_checks++;
      if (bus.memdata !== 8'h80) begin
         $display("FAIL full_mem128 got %h want 80", bus.memdata); n_fail++;
      end
      bus.memread = 1'b0;
      tick();
      n_checks++;
      if (load_count !== 9'd256) begin
         $display("FAIL full_count_hold got %0d want 256", load_count); n_fail++;
      end
   endtask

   task automatic test_reload_reset();
      logic [7:0] exp [3];
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h02;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      n_checks++;
      if (cpu_reset !== 1'b1 || run !== 1'b0 || load_count !== 9'd0) begin
         $display("FAIL reload_start got cpu_reset=%b run=%b count=%0d want 1/0/0",
                  cpu_reset, run, load_count);
         n_fail++;
      end
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = exp[i];
         tick();
      end
      load_valid = 1'b0;
      n_checks++;
      if (load_count !== 9'd2) begin
         $display("FAIL reload_count2 got %0d want 2", load_count); n_fail++;
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (run !== 1'b0 || cpu_reset !== 1'b1 || load_count !== 9'd0 || load_ready !== 1'b0)
      begin
         $display("FAIL midload_reset got run=%b cpu_reset=%b count=%0d ready=%b want 0/1/0/0",
                  run, cpu_reset, load_count, load_ready);
         n_fail++;
      end
      tick();
      reset       = 1'b1;
      bus.memread = 1'b1;
      bus.adr     = 8'h00;
      tick();
      bus.memread = 1'b0;
      n_checks++;
      if (bus.rd_valid !== 1'b0 || bus.memdata !== 8'h00) begin
         $display("FAIL idle_read_gated got data=%h valid=%b want 00/0", bus.memdata,
                  bus.rd_valid);
         n_fail++;
      end
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      n_checks++;
      if (run !== 1'b1 || cpu_reset !== 1'b0) begin
         $display("FAIL run_start got run=%b cpu_reset=%b want 1/0", run, cpu_reset);
         n_fail++;
      end
      for (int i = 0; i < 3; i++) begin
         bus.memread = 1'b1;
         bus.adr     = 8'(i);
         tick();
         n_checks++;
         if (bus.memdata !== exp[i] || bus.rd_valid !== 1'b1) begin
            $display("FAIL retained_%0d got data=%h valid=%b want %h/1", i, bus.memdata,
                     bus.rd_valid, exp[i]);
            n_fail++;
         end
      end
      bus.memread = 1'b0;
      tick();
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      load_start    = 1'b0;
      run_start     = 1'b0;
      load_valid    = 1'b0;
      load_data     = 8'h00;
      load_last     = 1'b0;
      bus.adr       = 8'h00;
      bus.writedata = 8'h00;
      bus.memread   = 1'b0;
      bus.memwrite  = 1'b0;
      #2;
      test_reset();
      test_load_fetch();
      test_write_read();
      test_gating();
      test_full_load();
      test_reload_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Byte-wide memory responder on the far side of the 8-bit multicycle MIPS core's memory interface (adr, writedata, memread, memwrite, memdata).
- Serves CPU reads with one-cycle registered latency and accepts CPU writes.
- Includes a streaming program loader that fills memory from address 0.
- Holds the core in reset, through `cpu_reset`, until loading completes.

Parameters:
- ADDR_W, 8, address width (matches core `adr`).
- DATA_W, 8, data width (matches core `memdata`/`writedata`).
- DEPTH, 256, number of bytes; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- adr  input  ADDR_W  CPU byte address.
- writedata  input  DATA_W  CPU write data.
- memread  input  1  CPU read request, sampled each clk.
- memwrite  input  1  CPU write request, sampled each clk.
- memdata  output  DATA_W  registered read data to CPU.
- rd_valid  output  1  one-cycle pulse: memdata updated by a read this cycle.
- load_start  input  1  begin (re)load; clears load address.
- run_start  input  1  go IDLE->RUN without loading.
- load_valid  input  1  loader byte present.
- load_data  input  DATA_W  loader byte.
- load_last  input  1  qualifies final loader byte.
- load_ready  output  1  loader may transfer (transfer = load_valid & load_ready).
- load_count  output  ADDR_W+1  bytes written in current load (0..DEPTH).
- cpu_reset  output  1  active-high reset to core; 1 whenever state != RUN.
- run  output  1  state == RUN.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - state=IDLE; memdata=0, rd_valid=0, load_ready=0, load_count=0, cpu_reset=1, run=0.
  - Memory array is not cleared; contents survive reset.
- All outputs are registered. `load_ready`, `cpu_reset` and `run` are decoded from the state register.
- States:
  - IDLE:
    - load_start -> LOAD; load_count<=0.
    - else run_start -> RUN.
    - load_start has priority over run_start.
  - LOAD:
    - load_ready=1 while load_count<DEPTH.
    - On transfer: mem[load_count[ADDR_W-1:0]]<=load_data; load_count<=load_count+1.
    - Transfer with load_last=1 -> RUN.
    - Transfer that makes load_count==DEPTH -> RUN, even without load_last. No wrap; address 0 is never overwritten by the loader.
    - load_valid with load_ready=0 is ignored.
    - load_start in LOAD restarts: load_count<=0, no write that cycle.
  - RUN:
    - cpu_reset=0 and run=1 from the first cycle in RUN.
    - load_start -> LOAD (load_count<=0); cpu_reset re-asserts next cycle.
    - run_start is ignored.
- CPU access, honoured only in RUN (state sampled at the edge):
  - memread=1: memdata<=mem[adr] at edge N; rd_valid=1 during cycle N+1 only. Latency 1 clk.
  - memwrite=1: mem[adr]<=writedata at edge.
  - memread and memwrite together, same adr: read returns pre-write contents (read-before-write); write still occurs.
  - memread=0: memdata holds last value; rd_valid=0.
- In IDLE/LOAD: CPU memread/memwrite are ignored, memdata holds, rd_valid=0.
- load_count holds its final value in RUN until the next load_start.
- Loader-port inputs are ignored outside LOAD, except load_start.
- Reset mid-LOAD: bytes already written remain; load_count=0; state=IDLE.
- Reset mid-RUN: a write at the same edge as reset assertion is not guaranteed. A write completed on an earlier edge persists.

Test Plan:
- Reset, then check outputs.
  - Stimulus: reset=0 for 2 clks, then reset=1.
  - Required: memdata=0x00, rd_valid=0, cpu_reset=1, run=0, load_ready=0, load_count=0.
- Load and fetch.
  - Stimulus: load_start; stream 0x20,0x08,0x43,0x00 with load_last on 0x00.
  - Required: load_count=4. run=1 and cpu_reset=0 the cycle after the last transfer.
  - Then memread with adr=0..3 on consecutive clks: memdata=0x20,0x08,0x43,0x00, each one cycle after its request, rd_valid high 4 cycles.
- Write then read.
  - Stimulus: in RUN, memwrite adr=0x80 writedata=0x5A; next clk memread adr=0x80.
  - Required: memdata=0x5A with rd_valid=1.
  - Simultaneous memread+memwrite adr=0x80 writedata=0xA5: memdata=0x5A that cycle; a following read returns 0xA5.
- Full load.
  - Stimulus: stream 256 bytes (value=index) without load_last.
  - Required: after the 256th transfer load_ready=0, load_count=256, state=RUN; mem[0]=0x00, mem[255]=0xFF.
- Gating.
  - Stimulus: in LOAD, drive memwrite adr=0x10 writedata=0xEE.
  - Required: mem[0x10] unchanged; memread in IDLE gives rd_valid=0 and memdata held.
- Reload and reset recovery.
  - Stimulus: in RUN, pulse load_start.
  - Required: cpu_reset=1 next cycle, load_count=0.
  - Then assert reset mid-load after 2 bytes: state=IDLE, bytes 0..1 retained. run_start gives RUN with those contents readable.
